// File: rtl/contra_enemy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : contra_enemy_pkg
// Description : Shared state encoding, default tuning constants and small
//               helpers for the enemy motion and animation stages.
// Revision    : 1.0 - initial release
// ============================================================================
package contra_enemy_pkg;

    // Enemy behaviour states. The width is fixed so every stage that
    // consumes the state agrees on the encoding.
    typedef enum logic [1:0] {
        ST_PATROL  = 2'd0,
        ST_PAUSE   = 2'd1,
        ST_DEAD    = 2'd2,
        ST_RESPAWN = 2'd3
    } enemy_state_t;

    // Default geometry, in screen pixels
    localparam logic [9:0] c_x_min      = 10'd320;
    localparam logic [9:0] c_x_max      = 10'd600;
    localparam logic [9:0] c_x_spawn    = 10'd600;
    localparam logic [9:0] c_y_ground   = 10'd400;
    localparam logic [9:0] c_speed      = 10'd1;
    localparam logic [9:0] c_fire_range = 10'd200;

    // Default timing, in frames
    localparam int c_pause_frames = 16;
    localparam int c_dead_frames  = 60;
    localparam int c_fire_period  = 64;

    // Absolute horizontal distance between two 10-bit X positions. The
    // subtraction is done at 11-bit signed width so it can never wrap.
    function automatic logic [10:0] abs_diff11(input logic [9:0] a,
                                               input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 11'(-d) : 11'(d);
    endfunction

endpackage : contra_enemy_pkg
`default_nettype wire

// File: rtl/enemy_fire_timer.sv
`default_nettype none
// ============================================================================
// Module      : enemy_fire_timer
// Description : Shot cooldown. A load arms the cooldown with FIRE_PERIOD-1
//               frames; it then counts down once per frame and rests at 0.
//               ready is high while the cooldown is 0. clear forces it to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_fire_timer #(
    parameter int FIRE_PERIOD = 64
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic load,
    input  logic clear,
    output logic ready
);

    // FIRE_PERIOD-1 always fits in clog2(FIRE_PERIOD) bits; keep at least one bit
    localparam int                c_cd_w   = (FIRE_PERIOD > 2) ? $clog2(FIRE_PERIOD) : 1;
    localparam logic [c_cd_w-1:0] c_reload = c_cd_w'(FIRE_PERIOD - 1);

    logic [c_cd_w-1:0] r_cooldown;

    // Cooldown counter: clear beats load, load beats the per-frame decrement
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_cooldown <= '0;
        end else if (clear) begin
            r_cooldown <= '0;
        end else if (load) begin
            r_cooldown <= c_reload;
        end else if (r_cooldown != '0) begin
            r_cooldown <= r_cooldown - c_cd_w'(1);
        end
    end

    assign ready = (r_cooldown == '0);

endmodule : enemy_fire_timer
`default_nettype wire

// File: rtl/enemy_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : enemy_motion_ctrl
// Description : Ground enemy behaviour. Patrols between two X bounds, pauses
//               at each bound before turning, dies when hit, respawns after a
//               fixed delay and fires at the player when in range and facing.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_motion_ctrl
    import contra_enemy_pkg::*;
#(
    parameter logic [9:0] X_MIN        = c_x_min,
    parameter logic [9:0] X_MAX        = c_x_max,
    parameter logic [9:0] X_SPAWN      = c_x_spawn,
    parameter logic [9:0] Y_GROUND     = c_y_ground,
    parameter logic [9:0] SPEED        = c_speed,
    parameter int         PAUSE_FRAMES = c_pause_frames,
    parameter int         DEAD_FRAMES  = c_dead_frames,
    parameter logic [9:0] FIRE_RANGE   = c_fire_range,
    parameter int         FIRE_PERIOD  = c_fire_period
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       hit,
    input  logic [9:0] player_x,
    output logic [9:0] EnemyX,
    output logic [9:0] EnemyY,
    output logic       direction,
    output logic       stand,
    output logic       alive,
    output logic       fire
);

    // One frame counter serves both the pause and the death timers, since
    // the two states are never active together.
    localparam int c_max_frames = (PAUSE_FRAMES > DEAD_FRAMES) ? PAUSE_FRAMES : DEAD_FRAMES;
    localparam int c_cnt_w      = (c_max_frames > 1) ? $clog2(c_max_frames) : 1;
    localparam logic [c_cnt_w-1:0] c_pause_last = c_cnt_w'(PAUSE_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_dead_last  = c_cnt_w'(DEAD_FRAMES - 1);

    enemy_state_t       r_state;
    enemy_state_t       w_state_next;
    logic [9:0]         r_x;
    logic [9:0]         w_x_next;
    logic               r_dir;
    logic               w_dir_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               r_fire;

    logic               w_reach_min;
    logic               w_reach_max;
    logic               w_alive;
    logic               w_player_left;
    logic               w_player_right;
    logic               w_facing;
    logic               w_in_range;
    logic               w_ready;
    logic               w_fire_req;
    logic               w_fire_load;
    logic               w_cd_clear;

    // A step that would land on or beyond a bound ends at that bound. The
    // sums are taken at 11 bits so a large SPEED cannot wrap past zero or 1023.
    assign w_reach_min = ({1'b0, r_x}) <= ({1'b0, X_MIN} + {1'b0, SPEED});
    assign w_reach_max = ({1'b0, r_x} + {1'b0, SPEED}) >= {1'b0, X_MAX};

    // State register plus position, facing, frame counter and shot pulse
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_PATROL;
            r_x     <= X_SPAWN;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_fire  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_dir   <= w_dir_next;
            r_cnt   <= w_cnt_next;
            // A hit this frame means the next frame is DEAD, so no shot leaves
            r_fire  <= w_fire_load;
        end
    end

    // Next-state logic, with hit taking priority over bound and pause expiry
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_dir_next   = r_dir;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_PATROL: begin
                if (hit) begin
                    w_state_next = ST_DEAD;
                    w_cnt_next   = '0;
                end else if (!r_dir) begin
                    if (w_reach_min) begin
                        w_x_next     = X_MIN;
                        w_state_next = ST_PAUSE;
                        w_cnt_next   = '0;
                    end else begin
                        w_x_next = r_x - SPEED;
                    end
                end else begin
                    if (w_reach_max) begin
                        w_x_next     = X_MAX;
                        w_state_next = ST_PAUSE;
                        w_cnt_next   = '0;
                    end else begin
                        w_x_next = r_x + SPEED;
                    end
                end
            end
            ST_PAUSE: begin
                if (hit) begin
                    w_state_next = ST_DEAD;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_pause_last) begin
                    w_state_next = ST_PATROL;
                    w_dir_next   = ~r_dir;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            ST_DEAD: begin
                // Position is reloaded on entry to RESPAWN so the respawn
                // frame already shows the enemy at its spawn point.
                if (r_cnt == c_dead_last) begin
                    w_state_next = ST_RESPAWN;
                    w_cnt_next   = '0;
                    w_x_next     = X_SPAWN;
                    w_dir_next   = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            ST_RESPAWN: begin
                w_state_next = ST_PATROL;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = ST_PATROL;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs and the shot request derived from the current state
    always_comb begin
        w_alive        = (r_state == ST_PATROL) || (r_state == ST_PAUSE);
        w_player_left  = player_x < r_x;
        w_player_right = player_x > r_x;
        // Equal X counts as facing in either direction
        w_facing       = w_player_left  ? ~r_dir :
                         w_player_right ?  r_dir : 1'b1;
        w_in_range     = abs_diff11(player_x, r_x) <= {1'b0, FIRE_RANGE};
        w_fire_req     = w_alive & w_ready & w_in_range & w_facing;
        w_fire_load    = w_fire_req & ~hit;
        w_cd_clear     = (r_state == ST_RESPAWN);

        EnemyX    = r_x;
        EnemyY    = Y_GROUND;
        direction = r_dir;
        stand     = (r_state == ST_PAUSE);
        alive     = w_alive;
        fire      = r_fire;
    end

    enemy_fire_timer #(
        .FIRE_PERIOD (FIRE_PERIOD)
    ) u_fire_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (w_fire_load),
        .clear     (w_cd_clear),
        .ready     (w_ready)
    );

endmodule : enemy_motion_ctrl
`default_nettype wire

// File: doc/enemy_motion_ctrl.md
ENEMY_MOTION_CTRL -- requirements
Module: enemy_motion_ctrl

Interface
REQ-001 Parameter X_MIN, default 10'd320, left patrol bound in pixels.
REQ-002 Parameter X_MAX, default 10'd600, right patrol bound in pixels.
REQ-003 Parameter X_SPAWN, default 10'd600, respawn X.
REQ-004 Parameter Y_GROUND, default 10'd400, constant enemy Y.
REQ-005 Parameter SPEED, default 10'd1, pixels moved per frame.
REQ-006 Parameter PAUSE_FRAMES, default 16, frames held at a bound before turning.
REQ-007 Parameter DEAD_FRAMES, default 60, frames spent dead before respawn.
REQ-008 Parameter FIRE_RANGE, default 10'd200, maximum |player_x - EnemyX| for firing.
REQ-009 Parameter FIRE_PERIOD, default 64, minimum frames between shots.
REQ-010 frame_clk  input  1  frame-rate clock; all state updates on its rising edge.
REQ-011 Reset  input  1  reset, asynchronous, active-high.
REQ-012 hit  input  1  player bullet collided with the enemy this frame.
REQ-013 player_x  input  10  player X position in pixels.
REQ-014 EnemyX  output  10  enemy X position.
REQ-015 EnemyY  output  10  enemy Y position, always Y_GROUND.
REQ-016 direction  output  1  facing: 0 = left, 1 = right; drives the run-animation stage.
REQ-017 stand  output  1  high while the enemy is stationary (PAUSE); the animation stage shows the standing frame.
REQ-018 alive  output  1  high in PATROL and PAUSE.
REQ-019 fire  output  1  one-frame shot request.

Function
REQ-020 The FSM SHALL have states PATROL, PAUSE, DEAD, RESPAWN.
REQ-021 PATROL: EnemyX SHALL move by SPEED per frame toward direction; if the next X would pass X_MIN or X_MAX, EnemyX SHALL clamp to that bound and the FSM SHALL enter PAUSE.
REQ-022 PAUSE: EnemyX SHALL hold; after exactly PAUSE_FRAMES frames, direction SHALL invert and the FSM SHALL return to PATROL.
REQ-023 In PATROL or PAUSE, hit=1 SHALL enter DEAD on the next edge; hit SHALL take priority over a bound or pause expiry in the same frame.
REQ-024 DEAD: alive=0, fire=0, EnemyX held, hit ignored; after exactly DEAD_FRAMES frames the FSM SHALL enter RESPAWN.
REQ-025 RESPAWN SHALL last one frame, load EnemyX=X_SPAWN and direction=0, and clear the fire cooldown, then enter PATROL.
REQ-026 fire SHALL pulse for one frame when alive, the cooldown is 0, |player_x - EnemyX| <= FIRE_RANGE, and direction faces the player (player_x < EnemyX requires direction 0; player_x > EnemyX requires direction 1; equal X counts as facing).
REQ-027 Each fire pulse SHALL load the cooldown with FIRE_PERIOD-1; the cooldown SHALL decrement once per frame and saturate at 0.
REQ-028 The distance SHALL be computed at 11-bit signed width so that no wrap-around occurs.
REQ-029 stand SHALL be 1 only in PAUSE.

Reset
REQ-030 On Reset: state=PATROL, EnemyX=X_SPAWN, direction=0, all counters 0, fire=0, stand=0, alive=1, EnemyY=Y_GROUND.
REQ-031 Reset asserted in any state, including mid-pause or mid-death, SHALL return the block to the REQ-030 values immediately.

Structure
REQ-032 The state enum and default constants SHALL be defined in shared package contra_enemy_pkg, for reuse by other enemy stages.
REQ-033 The cooldown logic SHALL be a sub-module, enemy_fire_timer (inputs: load, clear; output: ready).

Verification
REQ-034 Reset, no hit, player_x=0 -> EnemyX decrements 600 to 320 over 280 frames; stand=1 for 16 frames; direction becomes 1; EnemyX then rises.
REQ-035 hit pulse on the same frame EnemyX reaches 320 -> DEAD (alive=0) rather than PAUSE; 60 frames later RESPAWN; EnemyX=600, direction=0.
REQ-036 player_x=500 with the enemy at 600 facing left -> fire on the first eligible frame, then exactly every 64 frames while eligible.
REQ-037 player_x=700 with the enemy facing left -> fire never asserts; player_x=300 with EnemyX=600 (distance 300) -> no fire.
REQ-038 Reset asserted during frame 30 of DEAD -> next frame alive=1, EnemyX=600, state PATROL.
REQ-039 SPEED=7 with X_MIN=320 -> EnemyX clamps exactly at 320 with no underflow.
